// File: rtl/dct4x4_ctrl_if.sv
// Bundle of the row-input, shared-datapath and coefficient-output signals of dct4x4_ctrl.
// The master modport is the controller side; slave is the surrounding environment.
interface dct4x4_ctrl_if #(
  parameter int unsigned WIDTH_X = 16,
  parameter int unsigned WIDTH_Y = 22
);
  // Residual-row input handshake
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH_X-1:0] in_x0, in_x1, in_x2, in_x3;
  // Shared butterfly datapath
  logic                      dp_load;
  logic signed [WIDTH_X-1:0] dp_x0, dp_x1, dp_x2, dp_x3;
  logic signed [WIDTH_Y-1:0] dp_y0, dp_y1, dp_y2, dp_y3;
  // Coefficient output stream
  logic                      out_valid;
  logic [1:0]                out_col;
  logic signed [WIDTH_Y-1:0] out_y0, out_y1, out_y2, out_y3;
  logic                      busy;
  logic                      done;

  modport master (
    input  in_valid, in_x0, in_x1, in_x2, in_x3,
    input  dp_y0, dp_y1, dp_y2, dp_y3,
    output in_ready,
    output dp_load, dp_x0, dp_x1, dp_x2, dp_x3,
    output out_valid, out_col, out_y0, out_y1, out_y2, out_y3,
    output busy, done
  );

  modport slave (
    output in_valid, in_x0, in_x1, in_x2, in_x3,
    output dp_y0, dp_y1, dp_y2, dp_y3,
    input  in_ready,
    input  dp_load, dp_x0, dp_x1, dp_x2, dp_x3,
    input  out_valid, out_col, out_y0, out_y1, out_y2, out_y3,
    input  busy, done
  );
endinterface

// File: rtl/dct4x4_ctrl.sv
// Sequencer for a 2-D 4x4 forward transform on one shared 4-point butterfly datapath.
// Row pass feeds input rows, scales/saturates results into a transpose buffer; column pass
// re-issues buffer columns and streams the coefficients out. One block in flight at a time.
module dct4x4_ctrl #(
  parameter int unsigned WIDTH_X = 16,
  parameter int unsigned WIDTH_Y = 22,
  parameter int unsigned DP_LAT  = 2,
  parameter int unsigned SHIFT1  = 1
) (
  input logic           clk,
  input logic           rst,
  dct4x4_ctrl_if.master bus
);

  typedef enum logic [2:0] {StIdle, StRow, StRowWait, StCol, StColWait} state_e;

  // One entry per datapath load; travels alongside the operand through the datapath.
  typedef struct packed {
    logic       vld;
    logic       is_col;
    logic [1:0] idx;
  } tag_t;

  localparam logic signed [WIDTH_Y:0] RndHalf = (WIDTH_Y+1)'(2 ** (SHIFT1 - 1));
  localparam logic signed [WIDTH_Y:0] SatMax  = (WIDTH_Y+1)'(2 ** (WIDTH_X - 1) - 1);
  localparam logic signed [WIDTH_Y:0] SatMin  = ~SatMax;

  state_e     state_q, state_d;
  logic [2:0] rows_q, rows_d;   // rows accepted in this block
  logic [2:0] cap_q, cap_d;     // row results captured in this block
  logic [1:0] col_q, col_d;     // column being issued

  logic                      row_load_q;
  logic [1:0]                row_idx_q;
  logic signed [WIDTH_X-1:0] row_x_q [4];

  tag_t tag_q [DP_LAT];
  tag_t tag_in, tag_out;

  logic signed [WIDTH_X-1:0] tbuf_q [4][4];

  logic                      out_valid_q, done_q;
  logic [1:0]                out_col_q;
  logic signed [WIDTH_Y-1:0] out_y_q [4];

  logic signed [WIDTH_X-1:0] in_x [4];
  logic signed [WIDTH_Y-1:0] dp_y [4];
  logic signed [WIDTH_X-1:0] dp_x [4];
  logic signed [WIDTH_Y:0]   rnd_sum [4];
  logic signed [WIDTH_Y:0]   rnd_shr [4];
  logic signed [WIDTH_X-1:0] row_sat [4];

  logic in_ready, accept, col_issue, dp_load, row_cap, col_cap;

  assign in_x[0] = bus.in_x0;
  assign in_x[1] = bus.in_x1;
  assign in_x[2] = bus.in_x2;
  assign in_x[3] = bus.in_x3;
  assign dp_y[0] = bus.dp_y0;
  assign dp_y[1] = bus.dp_y1;
  assign dp_y[2] = bus.dp_y2;
  assign dp_y[3] = bus.dp_y3;

  // Reset gates in_ready directly so no row can slip in while rst is held.
  assign in_ready  = !rst && (state_q == StIdle || state_q == StRow) && (rows_q < 3'd4);
  assign accept    = bus.in_valid && in_ready;
  assign col_issue = (state_q == StCol);
  assign dp_load   = row_load_q || col_issue;

  assign tag_in  = '{vld: dp_load, is_col: col_issue, idx: (col_issue ? col_q : row_idx_q)};
  assign tag_out = tag_q[DP_LAT-1];
  assign row_cap = tag_out.vld && !tag_out.is_col;
  assign col_cap = tag_out.vld && tag_out.is_col;

  // Datapath operands: buffered column during COL, otherwise the registered input row.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dp_x[k] = col_issue ? tbuf_q[k][col_q] : row_x_q[k];
    end
  end

  // First-stage rounding shift and saturation of the row results back to input width.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rnd_sum[k] = {dp_y[k][WIDTH_Y-1], dp_y[k]} + RndHalf;
      rnd_shr[k] = rnd_sum[k] >>> SHIFT1;
      if (rnd_shr[k] > SatMax) begin
        row_sat[k] = SatMax[WIDTH_X-1:0];
      end else if (rnd_shr[k] < SatMin) begin
        row_sat[k] = SatMin[WIDTH_X-1:0];
      end else begin
        row_sat[k] = rnd_shr[k][WIDTH_X-1:0];
      end
    end
  end

  // Next-state and counter logic for the block sequencer.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cap_d   = cap_q;
    col_d   = col_q;
    if (accept) begin
      rows_d = rows_q + 3'd1;
    end
    if (row_cap) begin
      cap_d = cap_q + 3'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRow;
      end
      StRow: begin
        if (accept && rows_q == 3'd3) state_d = StRowWait;
      end
      StRowWait: begin
        // Columns start only once the 4th row result is in the buffer.
        if (row_cap && cap_q == 3'd3) state_d = StCol;
      end
      StCol: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = StColWait;
      end
      StColWait: begin
        // done_q marks the cycle column 3 is visible on the output.
        if (done_q) begin
          state_d = StIdle;
          rows_d  = 3'd0;
          cap_d   = 3'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rows_q  <= 3'd0;
      cap_q   <= 3'd0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cap_q   <= cap_d;
      col_q   <= col_d;
    end
  end

  // Input row register: an accepted row is presented to the datapath on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_load_q <= 1'b0;
      row_idx_q  <= 2'd0;
      for (int k = 0; k < 4; k++) row_x_q[k] <= '0;
    end else begin
      row_load_q <= accept;
      if (accept) begin
        row_idx_q <= rows_q[1:0];
        for (int k = 0; k < 4; k++) row_x_q[k] <= in_x[k];
      end
    end
  end

  // Tag delay line matching the datapath latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DP_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < DP_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Transpose buffer: row results written row-wise, read column-wise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) tbuf_q[r][k] <= '0;
      end
    end else if (row_cap) begin
      for (int k = 0; k < 4; k++) tbuf_q[tag_out.idx][k] <= row_sat[k];
    end
  end

  // Coefficient output register; out_y holds between columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_col_q   <= 2'd0;
      for (int k = 0; k < 4; k++) out_y_q[k] <= '0;
    end else begin
      out_valid_q <= col_cap;
      done_q      <= col_cap && (tag_out.idx == 2'd3);
      if (col_cap) begin
        out_col_q <= tag_out.idx;
        for (int k = 0; k < 4; k++) out_y_q[k] <= dp_y[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dp_load   = dp_load;
  assign bus.dp_x0     = dp_x[0];
  assign bus.dp_x1     = dp_x[1];
  assign bus.dp_x2     = dp_x[2];
  assign bus.dp_x3     = dp_x[3];
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_y0    = out_y_q[0];
  assign bus.out_y1    = out_y_q[1];
  assign bus.out_y2    = out_y_q[2];
  assign bus.out_y3    = out_y_q[3];
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_dct4x4_ctrl.sv
// Testbench for dct4x4_ctrl: registered butterfly datapath model, block-level reference model
// scheduling expected loads/outputs per cycle, directed scenarios plus randomized traffic.
module tb_dct4x4_ctrl;
  localparam int WX   = 16;
  localparam int WY   = 22;
  localparam int DL   = 2;
  localparam int SH   = 1;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct4x4_ctrl_if #(.WIDTH_X(WX), .WIDTH_Y(WY)) bus ();

  dct4x4_ctrl #(.WIDTH_X(WX), .WIDTH_Y(WY), .DP_LAT(DL), .SHIFT1(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got [%s], expected [%s]", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic int wrapy(input int v);
    logic [WY-1:0] t;
    t = v[WY-1:0];
    return int'($signed(t));
  endfunction

  function automatic void dp4(input int a0, input int a1, input int a2, input int a3,
                              output int y0, output int y1, output int y2, output int y3);
    y0 = wrapy(64 * (a0 + a1 + a2 + a3));
    y1 = wrapy(64 * (a0 - a3 + a1 - a2));
    y2 = wrapy(64 * (a0 + a3 - a1 - a2));
    y3 = wrapy(64 * (a0 - a3 - a1 + a2));
  endfunction

  function automatic int scale(input int y);
    int r;
    r = (y + (1 <<< (SH - 1))) >>> SH;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  int m_rows [4][4];
  int m_tb   [4][4];
  int m_coef [4][4];  // [column][k]

  function automatic void model_block();
    int y [4];
    for (int r = 0; r < 4; r++) begin
      dp4(m_rows[r][0], m_rows[r][1], m_rows[r][2], m_rows[r][3], y[0], y[1], y[2], y[3]);
      for (int k = 0; k < 4; k++) m_tb[r][k] = scale(y[k]);
    end
    for (int c = 0; c < 4; c++) begin
      dp4(m_tb[0][c], m_tb[1][c], m_tb[2][c], m_tb[3][c], y[0], y[1], y[2], y[3]);
      for (int k = 0; k < 4; k++) m_coef[c][k] = y[k];
    end
  endfunction

  // ---------------- datapath model (DP_LAT = 2, registered) ----------------
  logic signed [WY-1:0] s1 [4];
  logic signed [WY-1:0] s2 [4];
  always @(posedge clk) begin
    int y0, y1, y2, y3;
    dp4(int'(bus.dp_x0), int'(bus.dp_x1), int'(bus.dp_x2), int'(bus.dp_x3), y0, y1, y2, y3);
    s1[0] <= WY'(y0);
    s1[1] <= WY'(y1);
    s1[2] <= WY'(y2);
    s1[3] <= WY'(y3);
    s2 <= s1;
  end
  assign bus.dp_y0 = s2[0];
  assign bus.dp_y1 = s2[1];
  assign bus.dp_y2 = s2[2];
  assign bus.dp_y3 = s2[3];

  // ---------------- expected-event schedule ----------------
  bit exp_load [MAXC];
  int exp_x    [MAXC][4];
  bit exp_ov   [MAXC];
  int exp_col  [MAXC];
  int exp_y    [MAXC][4];
  bit exp_done [MAXC];
  int ready_from = 0;
  int rows_n = 0;
  int busy_from = MAXC;
  int busy_to = -1;
  int last_y [4] = '{0, 0, 0, 0};
  bit rst_prev = 1'b0;

  int t0 = 0;
  int n_acc = 0;
  string s_load = "", s_ov = "", s_done = "", s_acc = "";

  function automatic string app(input string s, input int v);
    return (s == "") ? $sformatf("%0d", v) : {s, ",", $sformatf("%0d", v)};
  endfunction

  always @(posedge clk) cyc++;

  // Compare DUT against the schedule, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    int c, dx [4], oy [4], ix [4];
    bit erdy;
    c = cyc;
    dx = '{int'(bus.dp_x0), int'(bus.dp_x1), int'(bus.dp_x2), int'(bus.dp_x3)};
    oy = '{int'(bus.out_y0), int'(bus.out_y1), int'(bus.out_y2), int'(bus.out_y3)};
    ix = '{int'(bus.in_x0), int'(bus.in_x1), int'(bus.in_x2), int'(bus.in_x3)};
    if (rst_prev) last_y = '{0, 0, 0, 0};
    if (exp_ov[c]) last_y = exp_y[c];
    erdy = !rst && (c >= ready_from);
    if (chk_on) begin
      chk("in_ready", int'(bus.in_ready), int'(erdy));
      chk("dp_load", int'(bus.dp_load), int'(exp_load[c]));
      if (exp_load[c]) for (int k = 0; k < 4; k++) chk("dp_x", dx[k], exp_x[c][k]);
      chk("out_valid", int'(bus.out_valid), int'(exp_ov[c]));
      if (exp_ov[c]) chk("out_col", int'(bus.out_col), exp_col[c]);
      for (int k = 0; k < 4; k++) chk("out_y", oy[k], last_y[k]);
      chk("done", int'(bus.done), int'(exp_done[c]));
      chk("busy", int'(bus.busy), int'(c >= busy_from && c <= busy_to));
      if (bus.done) chk("done_needs_col3", int'(bus.out_valid && bus.out_col == 2'd3), 1);
      if (bus.dp_load) s_load = app(s_load, c - t0);
      if (bus.out_valid) s_ov = app(s_ov, c - t0);
      if (bus.done) s_done = app(s_done, c - t0);
      if (bus.in_valid && bus.in_ready) begin
        s_acc = app(s_acc, c - t0);
        n_acc++;
      end
    end
    if (rst) begin
      for (int i = c + 1; i < c + 40 && i < MAXC; i++) begin
        exp_load[i] = 1'b0;
        exp_ov[i]   = 1'b0;
        exp_done[i] = 1'b0;
      end
      rows_n = 0;
      ready_from = c + 1;
      busy_from = MAXC;
      busy_to = c;
    end else if (bus.in_valid && erdy) begin
      exp_load[c+1] = 1'b1;
      exp_x[c+1] = ix;
      m_rows[rows_n] = ix;
      if (rows_n == 0) begin
        busy_from = c + 1;
        busy_to = MAXC;
      end
      rows_n++;
      if (rows_n == 4) begin
        model_block();
        for (int k = 0; k < 4; k++) begin
          exp_load[c+2+DL+k] = 1'b1;
          for (int j = 0; j < 4; j++) exp_x[c+2+DL+k][j] = m_tb[j][k];
          exp_ov[c+3+2*DL+k]  = 1'b1;
          exp_col[c+3+2*DL+k] = k;
          exp_y[c+3+2*DL+k]   = m_coef[k];
        end
        exp_done[c+6+2*DL] = 1'b1;
        ready_from = c + 7 + 2 * DL;
        busy_to = c + 6 + 2 * DL;
        rows_n = 0;
      end
    end
    rst_prev = rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int a0, input int a1, input int a2, input int a3);
    bus.in_x0 = WX'(a0);
    bus.in_x1 = WX'(a1);
    bus.in_x2 = WX'(a2);
    bus.in_x3 = WX'(a3);
  endtask

  task automatic start_scn();
    t0 = cyc;
    s_load = "";
    s_ov = "";
    s_done = "";
    s_acc = "";
    n_acc = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_dp_load"}, int'(bus.dp_load), 0);
    chk({tag, "_dp_x0"}, int'(bus.dp_x0), 0);
    chk({tag, "_dp_x1"}, int'(bus.dp_x1), 0);
    chk({tag, "_dp_x2"}, int'(bus.dp_x2), 0);
    chk({tag, "_dp_x3"}, int'(bus.dp_x3), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_col"}, int'(bus.out_col), 0);
    chk({tag, "_out_y0"}, int'(bus.out_y0), 0);
    chk({tag, "_out_y3"}, int'(bus.out_y3), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int bb [8][4];

  initial begin
    bus.in_valid = 1'b0;
    set_row(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) tick();
    chk_on = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.in_ready), 1);

    // Pin the reference model with hand-computed values.
    for (int r = 0; r < 4; r++) m_rows[r] = '{1, 1, 1, 1};
    model_block();
    chk("pin_dc_tb00", m_tb[0][0], 128);
    chk("pin_dc_tb31", m_tb[3][1], 0);
    chk("pin_dc_c0y0", m_coef[0][0], 32768);
    chk("pin_dc_c0y1", m_coef[0][1], 0);
    chk("pin_dc_c2y0", m_coef[2][0], 0);
    m_rows[0] = '{300, 300, 300, 300};
    for (int r = 1; r < 4; r++) m_rows[r] = '{-300, -300, -300, -300};
    model_block();
    chk("pin_sat_tb00", m_tb[0][0], 32767);
    chk("pin_sat_tb20", m_tb[2][0], -32768);
    chk("pin_sat_tb12", m_tb[1][2], 0);

    // DC block
    tick();
    start_scn();
    set_row(1, 1, 1, 1);
    bus.in_valid = 1'b1;
    repeat (4) tick();
    bus.in_valid = 1'b0;
    repeat (20) tick();
    chk_str("dc_loads", s_load, "1,2,3,4,7,8,9,10");
    chk_str("dc_out_valid", s_ov, "10,11,12,13");
    chk_str("dc_done", s_done, "13");

    // Saturation
    start_scn();
    bus.in_valid = 1'b1;
    set_row(300, 300, 300, 300);
    tick();
    set_row(-300, -300, -300, -300);
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (20) tick();
    chk_str("sat_done", s_done, "13");

    // Input gaps
    start_scn();
    set_row(1, 1, 1, 1);
    for (int r = 0; r < 10; r++) begin
      bus.in_valid = (r == 0 || r == 3 || r == 4 || r == 9);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (22) tick();
    chk_str("gap_loads", s_load, "1,4,5,10,13,14,15,16");
    chk_str("gap_out_valid", s_ov, "16,17,18,19");

    // Back-to-back blocks with in_valid held high
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) bb[r][k] = int'($urandom_range(0, 4000)) - 2000;
    end
    start_scn();
    for (int i = 0; i < 40; i++) begin
      if (n_acc < 8) set_row(bb[n_acc][0], bb[n_acc][1], bb[n_acc][2], bb[n_acc][3]);
      bus.in_valid = (n_acc < 8);
      tick();
    end
    bus.in_valid = 1'b0;
    chk_str("b2b_accepts", s_acc, "0,1,2,3,14,15,16,17");
    chk_str("b2b_done", s_done, "13,27");

    // Mid-block reset
    tick();
    start_scn();
    set_row(1, 1, 1, 1);
    bus.in_valid = 1'b1;
    repeat (4) tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_all_zero("midrst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(bus.in_ready), 1);
    repeat (30) tick();
    chk_str("midrst_loads", s_load, "1,2,3,4,7");
    chk_str("midrst_no_out", s_ov, "");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 900; i++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      if ((i / 100) % 2 == 0) begin
        set_row(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300,
                int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300);
      end else begin
        set_row(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
